ks_add_seq: RTL and testbench

//  Operand sequencer and result capture for the multi-cycle Kogge-Stone adder (ks_add).
//  - Accepts an operand pair on a valid/ready input channel.
//  - Holds the operands stable and keeps the adder enable high for the adder's full latency.
//  - Captures the sum and a signed-overflow flag, then presents them on a valid/ready output channel.
//  - Sits beside ks_add in the datapath parent: drives add_a/add_b/add_en, consumes add_out.

---
 rtl/ks_add_pkg.sv | 15 +
 rtl/ks_add_seq.sv | 135 +++++++++++++
 tb/tb_ks_add_seq.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ks_add_pkg.sv
// Shared types and helpers for the Kogge-Stone adder and its operand sequencer.
package ks_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ks_seq_state_t;

  // Adder edges from the first enabled edge until its output is valid.
  function automatic int ks_lat(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/ks_add_seq.sv
// Operand sequencer and result capture for the multi-cycle Kogge-Stone adder:
// valid/ready operand intake, adder enable for its full latency, valid/ready result.
module ks_add_seq
  import ks_add_pkg::*;
#(
  parameter int N   = 64,
  parameter int LAT = ks_lat(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf,
  output logic         add_en,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic [N-1:0] add_out
);

  localparam int            CW    = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  ks_seq_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          ovf_q, ovf_d;
  logic          in_ready_s;
  logic          add_en_s;
  logic          out_valid_s;
  logic          accept_s;

  assign accept_s = in_valid & in_ready_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: counter, held operands, captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (cnt_q == LAT_C) begin
          sum_d   = add_out;
          // Overflow: like-signed operands giving a result of the other sign.
          ovf_d   = (a_q[N-1] == b_q[N-1]) & (add_out[N-1] != a_q[N-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and adder-enable outputs decoded from state.
  always_comb begin
    in_ready_s  = 1'b0;
    add_en_s    = 1'b0;
    out_valid_s = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_s = ~rst;
      end
      RUN: begin
        add_en_s = 1'b1;
      end
      DONE: begin
        out_valid_s = 1'b1;
        in_ready_s  = out_ready & ~rst;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_s;
  assign add_en    = add_en_s;
  assign out_valid = out_valid_s;
  assign out_sum   = sum_q;
  assign out_ovf   = ovf_q;
  assign add_a     = a_q;
  assign add_b     = b_q;

endmodule

// File: tb/tb_ks_add_seq.sv
// Self-checking bench for ks_add_seq with a behavioural LAT-stage adder as the peer.
module tb_ks_add_seq;
  import ks_add_pkg::*;

  localparam int N   = 64;
  localparam int LAT = 7;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_ovf;
  logic         add_en;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic [N-1:0] add_out;

  ks_add_seq #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_out(add_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder stand-in: result valid LAT enabled edges after operands are presented.
  logic [N-1:0] pipe [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (add_en) begin
      pipe[0] <= add_a + add_b;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign add_out = pipe[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0] sum;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   en_cnt = 0;
  int   acc_count = 0;
  int   last_acc = -1;
  int   last_drain = -2;
  int   prev_acc = 0;
  bit   have_prev = 1'b0;
  bit   stream_on = 1'b0;
  logic ov_prev = 1'b0;

  // Scoreboard: push expectation on accept, pop and compare on drain.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      have_prev = 1'b0;
    end else begin
      exp_t e;
      logic [N:0] ext;
      cyc++;
      if (out_valid && out_ready) begin
        last_drain = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_sum", out_sum, e.sum);
          chk("sb_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
        end
      end
      if (in_valid && in_ready) begin
        ext   = {in_a[N-1], in_a} + {in_b[N-1], in_b};
        e.sum = ext[N-1:0];
        e.ovf = ext[N] ^ ext[N-1];
        e.acc = cyc;
        sb.push_back(e);
        acc_count++;
        last_acc = cyc;
        en_cnt = 0;
        if (stream_on && have_prev) chk("accept_spacing", 64'(cyc - prev_acc), 64'd9);
        prev_acc  = cyc;
        have_prev = stream_on;
      end else if (add_en) begin
        en_cnt++;
      end
    end
  end

  // Latency and enable-duration check on each rising out_valid.
  always @(negedge clk) begin
    if (!rst && out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        chk("valid_without_op", 64'd1, 64'd0);
      end else begin
        chk("latency", 64'(cyc - sb[0].acc), 64'(LAT + 1));
        chk("add_en_cycles", 64'(en_cnt), 64'(LAT + 1));
      end
    end
    ov_prev = rst ? 1'b0 : out_valid;
  end

  // Present an operand pair and return at the negedge after it is accepted.
  task automatic drive_op(input logic [N-1:0] a, input logic [N-1:0] b);
    bit ok = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_result(input string nm, input logic [N-1:0] es, input logic eo);
    bit got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      chk({nm, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({nm, "_sum"}, out_sum, es);
      chk({nm, "_ovf"}, {63'd0, out_ovf}, {63'd0, eo});
    end
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    logic         ovf;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_before;
    bit saw_v;
    vecs[0] = '{64'd3, 64'd5, 64'd8, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h2222_2222_2222_2211, 1'b0};
    vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_add_en", {63'd0, add_en}, 64'd0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
    chk("rst_add_a", add_a, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    // Table-driven single operations, including sign and wrap boundaries.
    foreach (vecs[i]) begin
      drive_op(vecs[i].a, vecs[i].b);
      in_valid = 1'b0;
      in_a = ~vecs[i].a;
      in_b = ~vecs[i].b;
      chk("add_a_held", add_a, vecs[i].a);
      wait_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].ovf);
    end
    @(negedge clk);

    // Backpressure with a pending operand pair.
    out_ready = 1'b0;
    drive_op(64'd100, 64'd23);
    in_valid = 1'b0;
    wait_result("bp_first", 64'd123, 1'b0);
    acc_before = acc_count;
    in_a = 64'd400;
    in_b = 64'd56;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_sum_stable", out_sum, 64'd123);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_add_en", {63'd0, add_en}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    chk("bp_no_accept", 64'(acc_count), 64'(acc_before));
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_drain_accept_same_edge", 64'(last_acc), 64'(last_drain));
    chk("bp_accept_count", 64'(acc_count), 64'(acc_before + 1));
    wait_result("bp_second", 64'd456, 1'b0);
    @(negedge clk);

    // Back-to-back random stream.
    stream_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_op({$urandom(), $urandom()}, {$urandom(), $urandom()});
    end
    in_valid = 1'b0;
    stream_on = 1'b0;
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    chk("stream_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);

    // Reset in the middle of an add (cnt==3).
    drive_op(64'h11, 64'h22);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_sum", out_sum, 64'd0);
    chk("midrst_add_en", {63'd0, add_en}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("midrst_add_a", add_a, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_v = 1'b0;
    repeat (15) begin
      @(negedge clk);
      saw_v = saw_v | out_valid;
    end
    chk("abandoned_no_valid", {63'd0, saw_v}, 64'd0);
    drive_op(64'd10, 64'd20);
    in_valid = 1'b0;
    wait_result("after_rst", 64'd30, 1'b0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
